// File: rtl/vga_text_pkg.sv
// rtl/vga_text_pkg.sv - shared constants, state enum and address helpers for the text console
package vga_text_pkg;

    localparam int COLS  = 70;
    localparam int ROWS  = 30;
    localparam int AW    = 12;
    localparam int CELLS = COLS * ROWS;

    localparam logic [7:0] SP = 8'h20;
    localparam logic [7:0] LF = 8'h0A;
    localparam logic [7:0] CR = 8'h0D;
    localparam logic [7:0] BS = 8'h08;

    typedef enum logic [1:0] {
        INIT_CLR,
        IDLE,
        PUT,
        LINE_CLR
    } state_t;

    // row*70 as row*64 + row*4 + row*2
    function automatic logic [AW-1:0] row_base(input logic [4:0] row);
        logic [AW-1:0] r;
        r = {{(AW-5){1'b0}}, row};
        return (r << 6) + (r << 2) + (r << 1);
    endfunction

    // logical row plus scroll offset, wrapped by a single conditional subtract
    function automatic logic [4:0] phys_row(input logic [4:0] row, input logic [4:0] top);
        logic [5:0] s;
        s = {1'b0, row} + {1'b0, top};
        if (s >= 6'(ROWS)) begin
            s = s - 6'(ROWS);
        end
        return s[4:0];
    endfunction

endpackage

// File: rtl/vga_text_console_vram_arb.sv
// rtl/vga_text_console_vram_arb.sv - VRAM port mux (display first) and display read return
module vram_arb
    import vga_text_pkg::*;
(
    input  logic          pclk,
    input  logic          reset,
    input  logic          disp_req,
    input  logic [AW-1:0] disp_addr,
    input  logic          wr_req,
    input  logic [AW-1:0] wr_addr,
    input  logic [7:0]    wr_data,
    output logic          wr_grant,
    output logic          vram_en,
    output logic          vram_we,
    output logic [AW-1:0] vram_addr,
    output logic [7:0]    vram_wdata,
    input  logic [7:0]    vram_rdata,
    output logic          disp_valid,
    output logic [7:0]    disp_char
);

    logic [7:0] char_hold;

    assign wr_grant   = wr_req & ~disp_req;
    assign vram_en    = disp_req | wr_req;
    assign vram_we    = wr_grant;
    assign vram_addr  = disp_req ? disp_addr : wr_addr;
    assign vram_wdata = wr_data;

    // Read data arrives the cycle after the request: pass it through while valid, hold it afterwards
    assign disp_char = disp_valid ? vram_rdata : char_hold;

    // Delay the display request by one cycle and capture the returned character
    always_ff @(posedge pclk) begin
        if (reset) begin
            disp_valid <= 1'b0;
            char_hold  <= 8'h00;
        end else begin
            disp_valid <= disp_req;
            if (disp_valid) begin
                char_hold <= vram_rdata;
            end
        end
    end

endmodule

// File: rtl/vga_text_console.sv
// rtl/vga_text_console.sv - character console: cursor, control codes, wrap and hardware scroll
module vga_text_console
    import vga_text_pkg::*;
(
    input  logic          pclk,
    input  logic          reset,
    input  logic          in_valid,
    input  logic [7:0]    in_char,
    output logic          in_ready,
    input  logic          disp_req,
    input  logic [6:0]    disp_x,
    input  logic [4:0]    disp_y,
    output logic          disp_valid,
    output logic [7:0]    disp_char,
    output logic          vram_en,
    output logic          vram_we,
    output logic [AW-1:0] vram_addr,
    output logic [7:0]    vram_wdata,
    input  logic [7:0]    vram_rdata,
    output logic [6:0]    cursor_x,
    output logic [4:0]    cursor_y
);

    state_t        state;
    logic [AW-1:0] clr_cnt;
    logic [7:0]    char_q;
    logic [6:0]    cx;
    logic [4:0]    cy;
    logic [4:0]    top;

    logic          wr_req;
    logic          wr_grant;
    logic [AW-1:0] wr_addr;
    logic [7:0]    wr_data;
    logic [AW-1:0] disp_addr;
    logic [AW-1:0] cur_row_base;
    logic          is_print;
    logic          bs_write;
    logic          newline;
    logic          scroll;
    logic          put_done;

    assign in_ready = (state == IDLE);
    assign cursor_x = cx;
    assign cursor_y = cy;

    // In LINE_CLR the cursor sits on the last logical row, which maps to the old top row
    assign cur_row_base = row_base(phys_row(cy, top));
    assign disp_addr    = row_base(phys_row(disp_y, top)) + {{(AW-7){1'b0}}, disp_x};

    assign is_print = (char_q >= 8'h20) && (char_q <= 8'h7E);
    assign bs_write = (char_q == BS) && (cx != 7'd0);
    assign newline  = (is_print && (cx == 7'(COLS-1))) || (char_q == LF);
    assign scroll   = newline && (cy == 5'(ROWS-1));
    assign put_done = (is_print || bs_write) ? wr_grant : 1'b1;

    // Write request, address and data for the current state
    always_comb begin
        wr_req  = 1'b0;
        wr_addr = '0;
        wr_data = SP;
        case (state)
            INIT_CLR: begin
                wr_req  = 1'b1;
                wr_addr = clr_cnt;
            end
            LINE_CLR: begin
                wr_req  = 1'b1;
                wr_addr = cur_row_base + clr_cnt;
            end
            PUT: begin
                if (is_print) begin
                    wr_req  = 1'b1;
                    wr_addr = cur_row_base + {{(AW-7){1'b0}}, cx};
                    wr_data = char_q;
                end else if (bs_write) begin
                    wr_req  = 1'b1;
                    wr_addr = cur_row_base + {{(AW-7){1'b0}}, cx - 7'd1};
                end
            end
            default: ;
        endcase
    end

    // Console sequencer: clears, byte handling, cursor and scroll offset
    always_ff @(posedge pclk) begin
        if (reset) begin
            state   <= INIT_CLR;
            clr_cnt <= '0;
            char_q  <= 8'h00;
            cx      <= 7'd0;
            cy      <= 5'd0;
            top     <= 5'd0;
        end else begin
            case (state)
                INIT_CLR: begin
                    if (wr_grant) begin
                        if (clr_cnt == AW'(CELLS-1)) begin
                            clr_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                IDLE: begin
                    if (in_valid) begin
                        char_q <= in_char;
                        state  <= PUT;
                    end
                end
                PUT: begin
                    if (put_done) begin
                        if (newline) begin
                            cx <= 7'd0;
                            if (scroll) begin
                                top   <= (top == 5'(ROWS-1)) ? 5'd0 : top + 5'd1;
                                state <= LINE_CLR;
                            end else begin
                                cy    <= cy + 5'd1;
                                state <= IDLE;
                            end
                        end else begin
                            if (is_print) begin
                                cx <= cx + 7'd1;
                            end else if (bs_write) begin
                                cx <= cx - 7'd1;
                            end else if (char_q == CR) begin
                                cx <= 7'd0;
                            end
                            state <= IDLE;
                        end
                    end
                end
                LINE_CLR: begin
                    if (wr_grant) begin
                        if (clr_cnt == AW'(COLS-1)) begin
                            clr_cnt <= '0;
                            state   <= IDLE;
                        end else begin
                            clr_cnt <= clr_cnt + 1'b1;
                        end
                    end
                end
                default: state <= INIT_CLR;
            endcase
        end
    end

    vram_arb u_arb (
        .pclk       (pclk),
        .reset      (reset),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_grant   (wr_grant),
        .vram_en    (vram_en),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .disp_valid (disp_valid),
        .disp_char  (disp_char)
    );

endmodule

// File: tb/tb_vga_text_console.sv
// tb/tb_vga_text_console.sv - scoreboard bench for vga_text_console
module tb_vga_text_console;
    import vga_text_pkg::*;

    logic          pclk = 1'b0;
    logic          reset = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_char = 8'h00;
    logic          in_ready;
    logic          disp_req = 1'b0;
    logic [6:0]    disp_x = 7'd0;
    logic [4:0]    disp_y = 5'd0;
    logic          disp_valid;
    logic [7:0]    disp_char;
    logic          vram_en;
    logic          vram_we;
    logic [AW-1:0] vram_addr;
    logic [7:0]    vram_wdata;
    logic [7:0]    vram_rdata = 8'h00;
    logic [6:0]    cursor_x;
    logic [4:0]    cursor_y;

    int total = 0;
    int bad = 0;

    logic [7:0]  mem     [CELLS];
    logic [7:0]  ref_mem [CELLS];
    logic [31:0] wq[$];
    logic [7:0]  dq[$];
    int mx, my, mtop;

    vga_text_console dut (
        .pclk       (pclk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_char    (in_char),
        .in_ready   (in_ready),
        .disp_req   (disp_req),
        .disp_x     (disp_x),
        .disp_y     (disp_y),
        .disp_valid (disp_valid),
        .disp_char  (disp_char),
        .vram_en    (vram_en),
        .vram_we    (vram_we),
        .vram_addr  (vram_addr),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .cursor_x   (cursor_x),
        .cursor_y   (cursor_y)
    );

    always #5 pclk = ~pclk;

    // single-port VRAM with one-cycle read latency
    always @(posedge pclk) begin
        if (vram_en && (int'(vram_addr) < CELLS)) begin
            if (vram_we) mem[vram_addr] <= vram_wdata;
            else vram_rdata <= mem[vram_addr];
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // scoreboard: VRAM writes and display returns checked mid-cycle
    always @(negedge pclk) begin
        if (!reset) begin
            if (disp_req) chk("disp_port", 32'({vram_en, vram_we}), 32'd2);
            if (vram_en && vram_we) begin
                if (wq.size() == 0) chk("wr_extra", 32'({vram_addr, vram_wdata}), 32'hffffffff);
                else chk("wr", 32'({vram_addr, vram_wdata}), wq.pop_front());
            end
            if (disp_valid) begin
                if (dq.size() == 0) chk("disp_extra", 32'(disp_char), 32'hffffffff);
                else chk("disp_char", 32'(disp_char), 32'(dq.pop_front()));
            end
        end
    end

    function automatic int paddr(input int row, input int col);
        return ((row + mtop) % ROWS) * COLS + col;
    endfunction

    task automatic exp_wr(input int a, input logic [7:0] d);
        wq.push_back(32'({a[11:0], d}));
        ref_mem[a] = d;
    endtask

    task automatic model_nl();
        int old;
        mx = 0;
        if (my < ROWS-1) my++;
        else begin
            old = mtop;
            mtop = (mtop + 1) % ROWS;
            for (int c = 0; c < COLS; c++) exp_wr(old*COLS + c, SP);
        end
    endtask

    task automatic model_byte(input logic [7:0] c);
        if (c >= 8'h20 && c <= 8'h7e) begin
            exp_wr(paddr(my, mx), c);
            if (mx == COLS-1) model_nl();
            else mx++;
        end else if (c == LF) model_nl();
        else if (c == CR) mx = 0;
        else if (c == BS && mx > 0) begin
            mx--;
            exp_wr(paddr(my, mx), SP);
        end
    endtask

    task automatic tick();
        @(posedge pclk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!in_ready && n < 5000) begin
            tick();
            n++;
        end
    endtask

    task automatic send(input logic [7:0] c);
        int n;
        int old_top;
        int exp_lat;
        wait_ready(n);
        in_valid = 1'b1;
        in_char  = c;
        tick();
        in_valid = 1'b0;
        old_top = mtop;
        model_byte(c);
        exp_lat = (mtop != old_top) ? 2 + COLS : 2;
        wait_ready(n);
        chk("ready", 32'(in_ready), 32'd1);
        chk("lat", n + 1, exp_lat);
        chk("cur_x", 32'(cursor_x), mx);
        chk("cur_y", 32'(cursor_y), my);
    endtask

    task automatic disp_read(input int x, input int y);
        disp_req = 1'b1;
        disp_x   = 7'(x);
        disp_y   = 5'(y);
        dq.push_back(ref_mem[paddr(y, x)]);
        #3;
        chk("disp_addr", 32'(vram_addr), paddr(y, x));
        tick();
    endtask

    task automatic apply_reset();
        int n;
        reset    = 1'b1;
        in_valid = 1'b0;
        disp_req = 1'b0;
        tick();
        wq.delete();
        dq.delete();
        chk("rst_ready", 32'(in_ready), 32'd0);
        chk("rst_dvalid", 32'(disp_valid), 32'd0);
        chk("rst_dchar", 32'(disp_char), 32'd0);
        chk("rst_cursor", 32'({cursor_x, cursor_y}), 32'd0);
        chk("rst_port", 32'({vram_en, vram_we, vram_addr, vram_wdata}), 32'({2'b11, 12'd0, 8'h20}));
        mx = 0; my = 0; mtop = 0;
        for (int a = 0; a < CELLS; a++) exp_wr(a, SP);
        tick();
        reset = 1'b0;
        wait_ready(n);
        chk("init_ready", 32'(in_ready), 32'd1);
        chk("init_cycles", n, CELLS);
        chk("init_left", wq.size(), 0);
    endtask

    initial begin
        int n;
        apply_reset();

        send("A");
        send("B");
        chk("ab_cursor", 32'({cursor_x, cursor_y}), 32'({7'd2, 5'd0}));
        send(LF);
        chk("lf_cursor", 32'({cursor_x, cursor_y}), 32'({7'd0, 5'd1}));
        send("C");
        disp_read(0, 0);
        disp_read(1, 0);
        disp_read(0, 1);
        disp_req = 1'b0;
        tick();

        apply_reset();
        for (int i = 0; i < 71; i++) send(8'(8'h61 + i % 26));
        chk("wrap_cursor", 32'({cursor_x, cursor_y}), 32'({7'd1, 5'd1}));
        repeat (28) send(LF);
        chk("row29", 32'(cursor_y), 32'd29);
        send(LF);
        chk("scroll_cursor", 32'({cursor_x, cursor_y}), 32'({7'd0, 5'd29}));
        disp_read(0, 0);
        disp_read(5, 29);
        disp_req = 1'b0;
        tick();

        wait_ready(n);
        in_valid = 1'b1;
        in_char  = "X";
        tick();
        in_valid = 1'b0;
        model_byte("X");
        for (int k = 0; k < 5; k++) disp_read(k, 0);
        disp_req = 1'b0;
        #3;
        chk("x_wr_we", 32'(vram_we), 32'd1);
        chk("x_wr_addr", 32'(vram_addr), paddr(my, mx - 1));
        wait_ready(n);
        chk("hold_lat", 5 + n + 1, 7);
        chk("x_cursor", 32'({cursor_x, cursor_y}), 32'({7'd1, 5'd29}));

        send(BS);
        send(BS);
        send(8'h07);
        chk("noop_cursor", 32'({cursor_x, cursor_y}), 32'({7'd0, 5'd29}));
        send("Q");
        send(CR);
        disp_read(0, 29);
        disp_req = 1'b0;
        tick();

        wait_ready(n);
        in_valid = 1'b1;
        in_char  = LF;
        tick();
        in_valid = 1'b0;
        model_byte(LF);
        repeat (10) tick();
        apply_reset();

        tick();
        tick();
        chk("wq_empty", wq.size(), 0);
        chk("dq_empty", dq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
